// File: rtl/mips_ctrl_pkg.sv
// Shared MIPS control definitions: opcodes, ALUOp encoding and the control bundle
// used between the ID-stage decoder and the EX-stage ALU controller.
package mips_ctrl_pkg;

    localparam int OPW    = 6;
    localparam int ALUOPW = 3;
    localparam int REGW   = 5;

    localparam logic [OPW-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OPW-1:0] OP_LW    = 6'b100011;
    localparam logic [OPW-1:0] OP_SW    = 6'b101011;
    localparam logic [OPW-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OPW-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OPW-1:0] OP_SLTI  = 6'b001010;

    localparam logic [ALUOPW-1:0] ALUOP_MEM  = 3'b000;
    localparam logic [ALUOPW-1:0] ALUOP_BR   = 3'b001;
    localparam logic [ALUOPW-1:0] ALUOP_R    = 3'b010;
    localparam logic [ALUOPW-1:0] ALUOP_ADDI = 3'b011;
    localparam logic [ALUOPW-1:0] ALUOP_SLTI = 3'b100;

    // Field order is shared with the EX stage; keep it stable.
    typedef struct packed {
        logic              reg_write;
        logic              reg_dst;
        logic              alu_src;
        logic              mem_read;
        logic              mem_write;
        logic              mem_to_reg;
        logic              branch;
        logic [ALUOPW-1:0] alu_op;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '{
        reg_write: 1'b0, reg_dst: 1'b0, alu_src: 1'b0, mem_read: 1'b0,
        mem_write: 1'b0, mem_to_reg: 1'b0, branch: 1'b0, alu_op: ALUOP_MEM
    };

endpackage

// File: rtl/id_ex_ctrl_decoder_main_decoder.sv
// Pure combinational main control decoder: opcode in, control bundle plus
// illegal/uses_rt flags out. Unknown opcodes decode to an all-zero bundle.
module main_decoder
    import mips_ctrl_pkg::*;
(
    input  logic [OPW-1:0] opcode,
    output ctrl_t          ctrl,
    output logic           illegal,
    output logic           uses_rt
);

    // Opcode to control-bundle lookup.
    always_comb begin
        ctrl    = CTRL_BUBBLE;
        illegal = 1'b0;
        uses_rt = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
                ctrl.alu_op    = ALUOP_R;
                uses_rt        = 1'b1;
            end
            OP_LW: begin
                ctrl.reg_write  = 1'b1;
                ctrl.alu_src    = 1'b1;
                ctrl.mem_read   = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.alu_op     = ALUOP_MEM;
            end
            OP_SW: begin
                ctrl.alu_src   = 1'b1;
                ctrl.mem_write = 1'b1;
                ctrl.alu_op    = ALUOP_MEM;
                uses_rt        = 1'b1;
            end
            OP_BEQ: begin
                ctrl.branch = 1'b1;
                ctrl.alu_op = ALUOP_BR;
                uses_rt     = 1'b1;
            end
            OP_ADDI: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.alu_op    = ALUOP_ADDI;
            end
            OP_SLTI: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.alu_op    = ALUOP_SLTI;
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/id_ex_ctrl_decoder.sv
// ID-stage control decode, load-use hazard detection and the ID/EX control
// pipeline register with flush/hold/stall bubble insertion.
module id_ex_ctrl_decoder
    import mips_ctrl_pkg::*;
#(
    parameter int OPW    = 6,
    parameter int ALUOPW = 3
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [31:0]       instr_i,
    input  logic              hold_i,
    input  logic              flush_i,
    output logic              stall_o,
    output logic              illegal_o,
    output logic              ex_valid_o,
    output logic              ex_RegWrite_o,
    output logic              ex_RegDst_o,
    output logic              ex_ALUSrc_o,
    output logic              ex_MemRead_o,
    output logic              ex_MemWrite_o,
    output logic              ex_MemtoReg_o,
    output logic              ex_Branch_o,
    output logic [ALUOPW-1:0] ex_ALUOp_o,
    output logic [OPW-1:0]    ex_funct_o,
    output logic [4:0]        ex_rs_o,
    output logic [4:0]        ex_rt_o,
    output logic [4:0]        ex_rd_o
);

    ctrl_t          dec_ctrl_s;
    logic           dec_illegal_s;
    logic           dec_uses_rt_s;
    logic           stall_s;

    ctrl_t          ex_ctrl_r,    ex_ctrl_nxt_s;
    logic           ex_valid_r,   ex_valid_nxt_s;
    logic           illegal_r,    illegal_nxt_s;
    logic [OPW-1:0] ex_funct_r,   ex_funct_nxt_s;
    logic [4:0]     ex_rs_r,      ex_rs_nxt_s;
    logic [4:0]     ex_rt_r,      ex_rt_nxt_s;
    logic [4:0]     ex_rd_r,      ex_rd_nxt_s;

    main_decoder u_main_decoder (
        .opcode  (instr_i[31:26]),
        .ctrl    (dec_ctrl_s),
        .illegal (dec_illegal_s),
        .uses_rt (dec_uses_rt_s)
    );

    // Load-use hazard against the load sitting in EX; a flush squashes ID anyway.
    always_comb begin
        stall_s = 1'b0;
        if (flush_i) begin
            stall_s = 1'b0;
        end else if (ex_valid_r && ex_ctrl_r.mem_read && (ex_rt_r != 5'd0)) begin
            stall_s = (ex_rt_r == instr_i[25:21]) ||
                      (dec_uses_rt_s && (ex_rt_r == instr_i[20:16]));
        end else begin
            stall_s = 1'b0;
        end
    end

    // Next ID/EX contents: flush beats hold beats stall beats normal load.
    always_comb begin
        ex_ctrl_nxt_s  = ex_ctrl_r;
        ex_valid_nxt_s = ex_valid_r;
        ex_funct_nxt_s = ex_funct_r;
        ex_rs_nxt_s    = ex_rs_r;
        ex_rt_nxt_s    = ex_rt_r;
        ex_rd_nxt_s    = ex_rd_r;
        illegal_nxt_s  = 1'b0;
        if (flush_i || (!hold_i && (stall_s || dec_illegal_s))) begin
            // Bubble; specifiers are zeroed so a bubble can never match a hazard.
            ex_ctrl_nxt_s  = CTRL_BUBBLE;
            ex_valid_nxt_s = 1'b0;
            ex_funct_nxt_s = 6'd0;
            ex_rs_nxt_s    = 5'd0;
            ex_rt_nxt_s    = 5'd0;
            ex_rd_nxt_s    = 5'd0;
            illegal_nxt_s  = !flush_i && !stall_s && dec_illegal_s;
        end else if (hold_i) begin
            illegal_nxt_s  = 1'b0;
        end else begin
            ex_ctrl_nxt_s  = dec_ctrl_s;
            ex_valid_nxt_s = 1'b1;
            ex_funct_nxt_s = instr_i[5:0];
            ex_rs_nxt_s    = instr_i[25:21];
            ex_rt_nxt_s    = instr_i[20:16];
            ex_rd_nxt_s    = instr_i[15:11];
        end
    end

    // ID/EX pipeline register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ex_ctrl_r  <= CTRL_BUBBLE;
            ex_valid_r <= 1'b0;
            illegal_r  <= 1'b0;
            ex_funct_r <= 6'd0;
            ex_rs_r    <= 5'd0;
            ex_rt_r    <= 5'd0;
            ex_rd_r    <= 5'd0;
        end else begin
            ex_ctrl_r  <= ex_ctrl_nxt_s;
            ex_valid_r <= ex_valid_nxt_s;
            illegal_r  <= illegal_nxt_s;
            ex_funct_r <= ex_funct_nxt_s;
            ex_rs_r    <= ex_rs_nxt_s;
            ex_rt_r    <= ex_rt_nxt_s;
            ex_rd_r    <= ex_rd_nxt_s;
        end
    end

    assign stall_o       = stall_s;
    assign illegal_o     = illegal_r;
    assign ex_valid_o    = ex_valid_r;
    assign ex_RegWrite_o = ex_ctrl_r.reg_write;
    assign ex_RegDst_o   = ex_ctrl_r.reg_dst;
    assign ex_ALUSrc_o   = ex_ctrl_r.alu_src;
    assign ex_MemRead_o  = ex_ctrl_r.mem_read;
    assign ex_MemWrite_o = ex_ctrl_r.mem_write;
    assign ex_MemtoReg_o = ex_ctrl_r.mem_to_reg;
    assign ex_Branch_o   = ex_ctrl_r.branch;
    assign ex_ALUOp_o    = ex_ctrl_r.alu_op;
    assign ex_funct_o    = ex_funct_r;
    assign ex_rs_o       = ex_rs_r;
    assign ex_rt_o       = ex_rt_r;
    assign ex_rd_o       = ex_rd_r;

endmodule

// File: tb/tb_id_ex_ctrl_decoder.sv
// Self-checking bench for id_ex_ctrl_decoder: directed test-plan steps followed by
// randomized instruction/hold/flush traffic checked against a behavioural model.
module tb_id_ex_ctrl_decoder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] instr = 32'd0;
    logic        hold = 1'b0;
    logic        flush = 1'b0;
    logic        stall_o, illegal_o, ex_valid_o;
    logic        ex_RegWrite_o, ex_RegDst_o, ex_ALUSrc_o, ex_MemRead_o;
    logic        ex_MemWrite_o, ex_MemtoReg_o, ex_Branch_o;
    logic [2:0]  ex_ALUOp_o;
    logic [5:0]  ex_funct_o;
    logic [4:0]  ex_rs_o, ex_rt_o, ex_rd_o;

    int total = 0;
    int bad = 0;

    // Model of the EX slot. Control packed as
    // {RegWrite,RegDst,ALUSrc,MemRead,MemWrite,MemtoReg,Branch,ALUOp[2:0]}.
    logic [9:0]  m_ctl;
    logic        m_valid, m_ill;
    logic [5:0]  m_funct;
    logic [4:0]  m_rs, m_rt, m_rd;

    id_ex_ctrl_decoder dut (
        .clk_i(clk), .rst_i(rst), .instr_i(instr), .hold_i(hold), .flush_i(flush),
        .stall_o(stall_o), .illegal_o(illegal_o), .ex_valid_o(ex_valid_o),
        .ex_RegWrite_o(ex_RegWrite_o), .ex_RegDst_o(ex_RegDst_o), .ex_ALUSrc_o(ex_ALUSrc_o),
        .ex_MemRead_o(ex_MemRead_o), .ex_MemWrite_o(ex_MemWrite_o),
        .ex_MemtoReg_o(ex_MemtoReg_o), .ex_Branch_o(ex_Branch_o),
        .ex_ALUOp_o(ex_ALUOp_o), .ex_funct_o(ex_funct_o),
        .ex_rs_o(ex_rs_o), .ex_rt_o(ex_rt_o), .ex_rd_o(ex_rd_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mk(input int op, input int rs, input int rt,
                                       input int rd, input int fn);
        logic [31:0] w;
        w = {op[5:0], rs[4:0], rt[4:0], rd[4:0], 5'd0, fn[5:0]};
        return w;
    endfunction

    // Opcode table: returns {legal, uses_rt, control[9:0]}.
    function automatic logic [11:0] ref_dec(input logic [5:0] op);
        case (op)
            6'd0:    return {2'b11, 7'b1100000, 3'd2};
            6'd35:   return {2'b10, 7'b1011010, 3'd0};
            6'd43:   return {2'b11, 7'b0010100, 3'd0};
            6'd4:    return {2'b11, 7'b0000001, 3'd1};
            6'd8:    return {2'b10, 7'b1010000, 3'd3};
            6'd10:   return {2'b10, 7'b1010000, 3'd4};
            default: return 12'd0;
        endcase
    endfunction

    function automatic logic ref_stall(input logic [31:0] ins, input logic f);
        logic [11:0] d;
        d = ref_dec(ins[31:26]);
        if (f || !m_valid || !m_ctl[6] || m_rt == 5'd0) return 1'b0;
        return (m_rt == ins[25:21]) || (d[10] && m_rt == ins[20:16]);
    endfunction

    task automatic model_bubble(input logic ill);
        m_ctl = 10'd0; m_valid = 1'b0; m_ill = ill;
        m_funct = 6'd0; m_rs = 5'd0; m_rt = 5'd0; m_rd = 5'd0;
    endtask

    task automatic model_edge(input logic [31:0] ins, input logic h, input logic f,
                              input logic st);
        logic [11:0] d;
        d = ref_dec(ins[31:26]);
        if (f) model_bubble(1'b0);
        else if (h) m_ill = 1'b0;
        else if (st) model_bubble(1'b0);
        else if (!d[11]) model_bubble(1'b1);
        else begin
            m_ctl = d[9:0]; m_valid = 1'b1; m_ill = 1'b0;
            m_funct = ins[5:0]; m_rs = ins[25:21]; m_rt = ins[20:16]; m_rd = ins[15:11];
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("ctrl", {22'd0, ex_RegWrite_o, ex_RegDst_o, ex_ALUSrc_o, ex_MemRead_o,
                     ex_MemWrite_o, ex_MemtoReg_o, ex_Branch_o, ex_ALUOp_o}, {22'd0, m_ctl});
        chk("valid", {31'd0, ex_valid_o}, {31'd0, m_valid});
        chk("illegal", {31'd0, illegal_o}, {31'd0, m_ill});
        chk("funct", {26'd0, ex_funct_o}, {26'd0, m_funct});
        chk("regs", {17'd0, ex_rs_o, ex_rt_o, ex_rd_o}, {17'd0, m_rs, m_rt, m_rd});
    endtask

    // Drive one ID instruction, check the hazard output, clock, check EX contents.
    task automatic step(input logic [31:0] ins, input logic h, input logic f);
        logic st;
        instr = ins; hold = h; flush = f;
        #1;
        st = ref_stall(ins, f);
        chk("stall", {31'd0, stall_o}, {31'd0, st});
        @(posedge clk);
        model_edge(ins, h, f, st);
        #1;
        check_all();
    endtask

    initial begin
        logic [5:0] op;
        int r;
        model_bubble(1'b0);
        #3;
        check_all();
        chk("reset_stall", {31'd0, stall_o}, 32'd0);
        #9 rst = 1'b1;

        // R-type add $3,$1,$2
        step(mk(0, 1, 2, 3, 32), 1'b0, 1'b0);
        chk("add_rd", {27'd0, ex_rd_o}, 32'd3);
        chk("add_aluop", {29'd0, ex_ALUOp_o}, 32'd2);

        // lw $5 then dependent add: one stall, bubble, then add enters EX
        step(mk(35, 1, 5, 0, 0), 1'b0, 1'b0);
        instr = mk(0, 5, 2, 6, 32); #1;
        chk("lu_stall_hi", {31'd0, stall_o}, 32'd1);
        step(mk(0, 5, 2, 6, 32), 1'b0, 1'b0);
        chk("lu_bubble", {31'd0, ex_valid_o}, 32'd0);
        step(mk(0, 5, 2, 6, 32), 1'b0, 1'b0);
        chk("lu_add_rd", {27'd0, ex_rd_o}, 32'd6);

        // lw $0 never stalls
        step(mk(35, 1, 0, 0, 0), 1'b0, 1'b0);
        step(mk(0, 0, 2, 6, 32), 1'b0, 1'b0);
        chk("zero_valid", {31'd0, ex_valid_o}, 32'd1);

        // flush with hold while slti in ID
        step(mk(10, 1, 2, 0, 5), 1'b1, 1'b1);
        chk("flush_aluop", {29'd0, ex_ALUOp_o}, 32'd0);

        // illegal opcode pulse, then addi
        step(mk(63, 1, 2, 3, 4), 1'b0, 1'b0);
        chk("ill_pulse", {31'd0, illegal_o}, 32'd1);
        step(mk(8, 1, 2, 0, 0), 1'b0, 1'b0);
        chk("ill_drop", {31'd0, illegal_o}, 32'd0);
        chk("addi_aluop", {29'd0, ex_ALUOp_o}, 32'd3);

        // sw then held for 3 cycles, reset mid-hold
        step(mk(43, 1, 2, 0, 0), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(mk(0, 7, 8, 9, 32), 1'b1, 1'b0);
        chk("hold_memwrite", {31'd0, ex_MemWrite_o}, 32'd1);
        rst = 1'b0; #1;
        model_bubble(1'b0);
        check_all();
        #2 rst = 1'b1;
        @(negedge clk);

        // Randomized traffic; small register range to provoke hazards
        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 7);
            case (r)
                0: op = 6'd0;  1: op = 6'd35; 2: op = 6'd43; 3: op = 6'd4;
                4: op = 6'd8;  5: op = 6'd35; default: op = 6'($urandom_range(0, 63));
            endcase
            step(mk(int'(op), $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 31), $urandom_range(0, 63)),
                 ($urandom_range(0, 9) == 0), ($urandom_range(0, 11) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/id_ex_ctrl_decoder.md
Name: id_ex_ctrl_decoder

Overview:
- ID-stage main control decoder plus ID/EX control pipeline register for the 5-stage MIPS pipeline. It is the producer of the ALUOp/funct pair consumed by the EX-stage ALU controller.
- Decodes the instruction word into datapath control and registers it for EX.
- Detects load-use hazards against the instruction currently in EX.
- Inserts bubbles on hazard or flush, and freezes on external hold.

Parameters:
- OPW, 6, opcode/funct field width
- ALUOPW, 3, ALUOp width (fixed encoding below)

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, asynchronous, active-low
- instr_i  in  32  IF/ID instruction word
- hold_i  in  1  global freeze (e.g. memory wait); ID/EX holds its value
- flush_i  in  1  branch taken in MEM; squash ID instruction
- stall_o  out  1  load-use hazard; IF/ID and PC must hold
- illegal_o  out  1  registered pulse; unknown opcode entered EX
- ex_valid_o  out  1  EX slot holds a real instruction
- ex_RegWrite_o, ex_RegDst_o, ex_ALUSrc_o, ex_MemRead_o, ex_MemWrite_o, ex_MemtoReg_o, ex_Branch_o  out  1 each  registered control
- ex_ALUOp_o  out  3  registered ALUOp
- ex_funct_o  out  6  registered instr[5:0]
- ex_rs_o, ex_rt_o, ex_rd_o  out  5 each  registered register specifiers

Behaviour:
- Reset (rst_i low, asynchronous): all ex_* outputs, illegal_o and ex_valid_o go to 0. stall_o is combinational from the registered state, so it is also 0.
- Decode (combinational from instr_i[31:26]):
  - R 000000: RegWrite=1, RegDst=1, ALUOp=010.
  - lw 100011: RegWrite=1, ALUSrc=1, MemRead=1, MemtoReg=1, ALUOp=000.
  - sw 101011: ALUSrc=1, MemWrite=1, ALUOp=000.
  - beq 000100: Branch=1, ALUOp=001.
  - addi 001000: RegWrite=1, ALUSrc=1, ALUOp=011.
  - slti 001010: RegWrite=1, ALUSrc=1, ALUOp=100.
  - Any other opcode: illegal. Decoded control is all-zero and the slot becomes a bubble.
  - Control signals not listed for an opcode are 0.
- uses_rt = 1 for R-type, sw and beq; 0 otherwise.
- Hazard (combinational): stall_o = ex_valid_o & ex_MemRead_o & (ex_rt_o != 0) & ((ex_rt_o == instr_i[25:21]) | (uses_rt & ex_rt_o == instr_i[20:16])). stall_o is forced to 0 while flush_i = 1.
- Register update each rising edge, priority in this order:
  1. flush_i = 1: load bubble (all control 0, valid 0, illegal_o 0). Applies even if hold_i = 1.
  2. hold_i = 1: all ex_* registers keep their values; illegal_o goes to 0.
  3. stall_o = 1: load bubble.
  4. Otherwise: load decoded control, ALUOp, funct and rs/rt/rd. valid = 1 unless the opcode is illegal. illegal_o = 1 for one cycle if the opcode is illegal.
- Bubble definition: all control and valid at 0. ALUOp = 000 and funct = 0. Specifiers are zeroed so no false hazards occur.
- Latency: one cycle from instr_i to ex_* outputs.
- A load-use stall lasts exactly one cycle. After the bubble, ex_MemRead_o = 0, so stall_o drops with an unchanged instr_i.
- Back-to-back loads to the same register stall once per dependent consumer. No cascade occurs.
- rt = 0 never causes a stall (writes to $zero are ignored).
- Reset asserted mid-stall clears state immediately. The first instruction after reset release never stalls.

Decomposition:
- Shared package (mips_ctrl_pkg): opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_SLTI).
- Same package: ALUOp constants ALUOP_MEM=000, ALUOP_BR=001, ALUOP_R=010, ALUOP_ADDI=011, ALUOP_SLTI=100. These are shared with the EX-stage ALU controller.
- Same package: control-bundle field order.
- One natural sub-module: main_decoder. It is pure combinational, opcode in and control bundle plus illegal/uses_rt out. The top holds the hazard logic and the pipeline register.

Test Plan:
- Reset, then R-type add $3,$1,$2 (funct 100000) -> next cycle ex_RegWrite=1, ex_RegDst=1, ex_ALUOp=010, ex_funct=100000, ex_rd=3, ex_valid=1.
- lw $5,0($1) then add $6,$5,$2 -> stall_o=1 for one cycle. The EX slot shows a bubble (valid 0). The add enters EX on the following cycle with stall_o=0.
- lw $0,0($1) then add $6,$0,$2 -> stall_o stays 0 and no bubble is inserted.
- flush_i=1 together with hold_i=1 while slti is in ID -> EX slot becomes a bubble, and ex_ALUOp_o=000 on the next edge.
- Opcode 111111 -> illegal_o=1 for exactly one cycle, ex_valid=0 and all control 0. A following addi gives ex_ALUOp=011 and ex_ALUSrc=1.
- hold_i=1 for 3 cycles after sw is loaded -> ex_MemWrite=1 and ex_ALUOp=000 stay stable. Asserting rst_i low mid-hold clears all outputs asynchronously.
